// File: rtl/phase_sequencer.sv
// Six-phase instruction sequencer: fetch, decode, regread, execute, memory, writeback.
// Stalls on the memory handshake in fetch and memory phases, with a stall timeout that faults.
module phase_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        inClk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        StepMode,
    input  logic        Step,
    input  logic        Halt,
    input  logic        MemAccess,
    input  logic        MemReady,
    output logic [5:0]  Phases,
    output logic        MemReq,
    output logic        Busy,
    output logic        Halted,
    output logic        Fault,
    output logic [15:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_P1,
        S_P2,
        S_P3,
        S_P4,
        S_P5,
        S_HALTED
    } state_t;

    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  stall_q, stall_d;
    logic        pend_q, pend_d;
    logic        fault_q, fault_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic        mem_wait;
    state_t      mem_next;

    // NOTE: reset is synchronous, so it only acts on a clock edge; state updates use <= so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge inClk) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            stall_q       <= '0;
            pend_q        <= 1'b0;
            fault_q       <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_q       <= stall_d;
            pend_q        <= pend_d;
            fault_q       <= fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        stall_d       = '0;
        pend_d        = pend_q;
        fault_d       = fault_q;
        instr_count_d = instr_count_q;
        mem_wait      = 1'b0;
        mem_next      = state_q;
        Phases        = 6'b000000;
        MemReq        = 1'b0;
        Busy          = 1'b0;
        Halted        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (StepMode ? Step : Run) state_d = S_P0;
            end
            S_P0: begin
                Phases   = 6'b000001;
                Busy     = 1'b1;
                MemReq   = 1'b1;
                mem_wait = 1'b1;
                mem_next = S_P1;
            end
            S_P1: begin
                Phases  = 6'b000010;
                Busy    = 1'b1;
                state_d = S_P2;
                if (Halt) pend_d = 1'b1;
            end
            S_P2: begin
                Phases  = 6'b000100;
                Busy    = 1'b1;
                state_d = S_P3;
            end
            S_P3: begin
                Phases  = 6'b001000;
                Busy    = 1'b1;
                state_d = S_P4;
            end
            S_P4: begin
                Phases   = 6'b010000;
                Busy     = 1'b1;
                MemReq   = MemAccess;
                mem_wait = MemAccess;
                mem_next = S_P5;
                if (!MemAccess) state_d = S_P5;
            end
            S_P5: begin
                Phases        = 6'b100000;
                Busy          = 1'b1;
                instr_count_d = instr_count_q + 16'd1;
                // A captured halt wins over both Run and StepMode here.
                if (pend_q)                state_d = S_HALTED;
                else if (StepMode || !Run) state_d = S_IDLE;
                else                       state_d = S_P0;
            end
            S_HALTED: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared handshake for the fetch and memory phases; the stall count restarts at zero
        // whenever the phase is left, since stall_d defaults to zero.
        if (mem_wait) begin
            if (MemReady) begin
                state_d = mem_next;
            end else if (stall_q == STALL_LAST) begin
                state_d = S_HALTED;
                fault_d = 1'b1;
            end else begin
                stall_d = stall_q + 8'd1;
            end
        end
    end

    assign Fault      = fault_q;
    assign InstrCount = instr_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a phase-number model is compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_phase_sequencer;

    localparam int TIMEOUT = 4;

    logic        inClk;
    logic        Reset;
    logic        Run;
    logic        StepMode;
    logic        Step;
    logic        Halt;
    logic        MemAccess;
    logic        MemReady;
    logic [5:0]  Phases;
    logic        MemReq;
    logic        Busy;
    logic        Halted;
    logic        Fault;
    logic [15:0] InstrCount;

    phase_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .inClk      (inClk),
        .Reset      (Reset),
        .Run        (Run),
        .StepMode   (StepMode),
        .Step       (Step),
        .Halt       (Halt),
        .MemAccess  (MemAccess),
        .MemReady   (MemReady),
        .Phases     (Phases),
        .MemReq     (MemReq),
        .Busy       (Busy),
        .Halted     (Halted),
        .Fault      (Fault),
        .InstrCount (InstrCount)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge inClk);
            #1;
        end
    endtask

    // Model: m_ph is the phase number, -1 while idle and 6 once halted.
    int          m_ph     = -1;
    int          m_stall  = 0;
    bit          m_pend   = 1'b0;
    bit          m_fault  = 1'b0;
    logic [15:0] m_count  = '0;
    bit          m_valid  = 1'b0;
    bit          preload  = 1'b0;
    bit          cmp_en   = 1'b1;

    function automatic bit m_waits_mem(input int ph, input logic acc);
        return (ph == 0) || (ph == 4 && acc);
    endfunction

    always @(posedge inClk) begin
        if (!Reset) begin
            m_ph    <= -1;
            m_stall <= 0;
            m_pend  <= 1'b0;
            m_fault <= 1'b0;
            m_count <= '0;
            m_valid <= 1'b1;
        end else if (preload) begin
            m_count <= 16'hFFFF;
        end else if (m_valid) begin
            if (m_ph == -1) begin
                if (StepMode ? Step : Run) m_ph <= 0;
            end else if (m_ph >= 0 && m_ph <= 5) begin
                if (m_waits_mem(m_ph, MemAccess) && !MemReady) begin
                    if (m_stall + 1 >= TIMEOUT) begin
                        m_ph    <= 6;
                        m_fault <= 1'b1;
                    end else begin
                        m_stall <= m_stall + 1;
                    end
                end else begin
                    m_stall <= 0;
                    if (m_ph == 1 && Halt) m_pend <= 1'b1;
                    if (m_ph < 5) begin
                        m_ph <= m_ph + 1;
                    end else begin
                        m_count <= m_count + 16'd1;
                        m_ph    <= m_pend ? 6 : ((StepMode || !Run) ? -1 : 0);
                    end
                end
            end
        end
    end

    always @(negedge inClk) begin
        if (m_valid && cmp_en) begin
            check("model_phases", 32'(Phases), (m_ph >= 0 && m_ph <= 5) ? 32'(6'b1 << m_ph) : 32'd0);
            check("model_memreq", 32'(MemReq), 32'(m_waits_mem(m_ph, MemAccess)));
            check("model_busy", 32'(Busy), 32'(m_ph >= 0 && m_ph <= 5));
            check("model_halted", 32'(Halted), 32'(m_ph == 6));
            check("model_fault", 32'(Fault), 32'(m_fault));
            check("model_count", 32'(InstrCount), 32'(m_count));
        end
    end

    logic [5:0] seq_tab [6];

    task automatic check_all_zero(input string name);
        check({name, "_phases"}, 32'(Phases), 32'd0);
        check({name, "_memreq"}, 32'(MemReq), 32'd0);
        check({name, "_busy"}, 32'(Busy), 32'd0);
        check({name, "_halted"}, 32'(Halted), 32'd0);
        check({name, "_fault"}, 32'(Fault), 32'd0);
        check({name, "_count"}, 32'(InstrCount), 32'd0);
    endtask

    initial begin
        seq_tab   = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
        Reset     = 1'b0;
        Run       = 1'b0;
        StepMode  = 1'b0;
        Step      = 1'b0;
        Halt      = 1'b0;
        MemAccess = 1'b0;
        MemReady  = 1'b0;
        cyc(2);
        check_all_zero("reset");

        // Free run with MemReady tied high: four back-to-back 6-cycle instructions.
        Reset    = 1'b1;
        Run      = 1'b1;
        MemReady = 1'b1;
        cyc(1);
        for (int i = 0; i < 24; i++) begin
            check("freerun_phase", 32'(Phases), 32'(seq_tab[i % 6]));
            cyc(1);
        end
        check("freerun_count4", 32'(InstrCount), 32'd4);
        Run = 1'b0;
        cyc(6);
        check("freerun_stop_busy", 32'(Busy), 32'd0);
        check("freerun_count5", 32'(InstrCount), 32'd5);

        // Three stall cycles in fetch, then three in memory with MemAccess=1.
        Run      = 1'b1;
        MemReady = 1'b0;
        cyc(1);
        Run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) MemReady = 1'b1;
            check("p0_stall_phase", 32'(Phases), 32'h01);
            check("p0_stall_req", 32'(MemReq), 32'd1);
            cyc(1);
        end
        MemReady  = 1'b0;
        MemAccess = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check("mid_phase", 32'(Phases), 32'(seq_tab[i]));
            check("mid_req", 32'(MemReq), 32'd0);
            cyc(1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) MemReady = 1'b1;
            check("p4_stall_phase", 32'(Phases), 32'h10);
            check("p4_stall_req", 32'(MemReq), 32'd1);
            cyc(1);
        end
        check("p4_done_phase", 32'(Phases), 32'h20);
        check("p4_no_fault", 32'(Fault), 32'd0);
        MemAccess = 1'b0;
        cyc(1);
        check("stall_idle_busy", 32'(Busy), 32'd0);
        check("stall_count6", 32'(InstrCount), 32'd6);

        // Single-step: two one-cycle Step pulses give two instructions.
        StepMode = 1'b1;
        Step     = 1'b1;
        cyc(1);
        Step = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("step_phase", 32'(Phases), 32'(seq_tab[i]));
            check("step_req", 32'(MemReq), 32'(i == 0));
            cyc(1);
        end
        check("step_gap_busy", 32'(Busy), 32'd0);
        cyc(1);
        check("step_gap_busy2", 32'(Busy), 32'd0);
        Step = 1'b1;
        cyc(1);
        Step = 1'b0;
        cyc(6);
        check("step_end_busy", 32'(Busy), 32'd0);
        check("step_count8", 32'(InstrCount), 32'd8);

        // Step held high: one idle cycle between instructions.
        Step = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            check("held_step_busy", 32'(Busy), 32'(k != 7 && k != 14));
        end
        Step = 1'b0;
        check("held_step_count10", 32'(InstrCount), 32'd10);

        // Halt seen in decode: instruction completes, is counted, then halts for good.
        StepMode = 1'b0;
        Run      = 1'b1;
        cyc(1);
        check("halt_p0", 32'(Phases), 32'h01);
        cyc(1);
        check("halt_p1", 32'(Phases), 32'h02);
        Halt = 1'b1;
        cyc(1);
        Halt     = 1'b0;
        Run      = 1'b0;
        StepMode = 1'b1;
        cyc(3);
        check("halt_p5", 32'(Phases), 32'h20);
        cyc(1);
        check("halt_halted", 32'(Halted), 32'd1);
        check("halt_phases", 32'(Phases), 32'd0);
        check("halt_count11", 32'(InstrCount), 32'd11);
        Run      = 1'b1;
        StepMode = 1'b0;
        Step     = 1'b1;
        cyc(4);
        check("halt_sticky", 32'(Halted), 32'd1);
        check("halt_sticky_count", 32'(InstrCount), 32'd11);
        Step  = 1'b0;
        Reset = 1'b0;
        cyc(1);
        check_all_zero("halt_reset");
        Reset = 1'b1;

        // Timeout: fourth consecutive fetch stall faults and halts.
        MemReady = 1'b0;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            check("to_phase", 32'(Phases), 32'h01);
            check("to_no_fault", 32'(Fault), 32'd0);
            cyc(1);
        end
        check("to_fault", 32'(Fault), 32'd1);
        check("to_halted", 32'(Halted), 32'd1);
        check("to_count", 32'(InstrCount), 32'd0);

        // Reset taking effect in execute.
        Reset = 1'b0;
        cyc(1);
        Reset    = 1'b1;
        MemReady = 1'b1;
        cyc(4);
        check("rst_mid_p3", 32'(Phases), 32'h08);
        Reset = 1'b0;
        cyc(1);
        check_all_zero("rst_mid");
        Reset = 1'b1;
        Run   = 1'b0;

        // Counter wrap from 16'hFFFF.
        cmp_en  = 1'b0;
        force dut.instr_count_q = 16'hFFFF;
        preload = 1'b1;
        cyc(1);
        preload = 1'b0;
        release dut.instr_count_q;
        check("wrap_preload", 32'(InstrCount), 32'hFFFF);
        cmp_en = 1'b1;
        Run    = 1'b1;
        cyc(1);
        Run = 1'b0;
        cyc(6);
        check("wrap_busy", 32'(Busy), 32'd0);
        check("wrap_count", 32'(InstrCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
